// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_narrow_unit
// Description : Narrows a 32-bit register value to byte/halfword/word and
//               writes it little-endian to a byte-wide data memory, one byte
//               per cycle, behind a req/ready handshake. A one-cycle done
//               pulse carries the alignment error and overflow flags.
//               Optional narrowing-overflow check: STORE_NARROW_OVF_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module store_narrow_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       data_i,
   input  logic [1:0]        size_i,
   output logic              ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   output logic              done_o,
   output logic              err_o,
   output logic              ovf_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;
   localparam logic [1:0] c_size_ill  = 2'b11;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic [31:0]       r_data, w_data_nxt;
   logic [1:0]        r_size, w_size_nxt;
   logic              r_err, w_err_nxt;
   logic              r_ovf, w_ovf_nxt;

   logic              w_illegal;
   logic              w_ovf_in;
   logic [1:0]        w_last_cnt;

   logic              r_ready, r_we, r_done, r_err_o, r_ovf_o;
   logic [ADDR_W-1:0] r_maddr;
   logic [7:0]        r_mdata;
   logic              w_we_nxt;
   logic [ADDR_W-1:0] w_maddr_nxt;
   logic [7:0]        w_mdata_nxt;

   // A request is illegal for size 11 or when the address is not naturally aligned
   assign w_illegal = (size_i == c_size_ill)
                    | ((size_i == c_size_half) & addr_i[0])
                    | ((size_i == c_size_word) & (|addr_i[1:0]));

`ifdef STORE_NARROW_OVF_CHECK_EN
   // Overflow when the discarded upper bits are not copies of the stored sign bit
   always_comb begin
      w_ovf_in = 1'b0;
      case (size_i)
         c_size_byte: w_ovf_in = ~((&data_i[31:7])  | ~(|data_i[31:7]));
         c_size_half: w_ovf_in = ~((&data_i[31:15]) | ~(|data_i[31:15]));
         default:     w_ovf_in = 1'b0;
      endcase
   end
`else
   assign w_ovf_in = 1'b0;
`endif

   // Index of the final byte for the captured access size
   always_comb begin
      w_last_cnt = 2'd3;
      case (r_size)
         c_size_byte: w_last_cnt = 2'd0;
         c_size_half: w_last_cnt = 2'd1;
         default:     w_last_cnt = 2'd3;
      endcase
   end

   // Next-state, capture and next-output decode; outputs are registered from these
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_base_nxt  = r_base;
      w_data_nxt  = r_data;
      w_size_nxt  = r_size;
      w_err_nxt   = r_err;
      w_ovf_nxt   = r_ovf;
      case (r_state)
         S_IDLE: begin
            if (req_i) begin
               w_base_nxt  = addr_i;
               w_data_nxt  = data_i;
               w_size_nxt  = size_i;
               w_cnt_nxt   = 2'd0;
               w_err_nxt   = w_illegal;
               w_ovf_nxt   = w_ovf_in & ~w_illegal;
               w_state_nxt = w_illegal ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            if (r_cnt == w_last_cnt) begin
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 2'd1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      w_we_nxt    = (w_state_nxt == S_WRITE);
      w_maddr_nxt = '0;
      w_mdata_nxt = '0;
      if (w_we_nxt) begin
         w_maddr_nxt = w_base_nxt + ADDR_W'(w_cnt_nxt);
         w_mdata_nxt = w_data_nxt[{w_cnt_nxt, 3'b000} +: 8];
      end
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_base  <= '0;
         r_data  <= '0;
         r_size  <= '0;
         r_err   <= 1'b0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b1;
         r_we    <= 1'b0;
         r_maddr <= '0;
         r_mdata <= '0;
         r_done  <= 1'b0;
         r_err_o <= 1'b0;
         r_ovf_o <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_base  <= w_base_nxt;
         r_data  <= w_data_nxt;
         r_size  <= w_size_nxt;
         r_err   <= w_err_nxt;
         r_ovf   <= w_ovf_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_we    <= w_we_nxt;
         r_maddr <= w_maddr_nxt;
         r_mdata <= w_mdata_nxt;
         r_done  <= (w_state_nxt == S_DONE);
         r_err_o <= (w_state_nxt == S_DONE) & w_err_nxt;
         r_ovf_o <= (w_state_nxt == S_DONE) & w_ovf_nxt;
      end
   end

   assign ready_o    = r_ready;
   assign mem_we_o   = r_we;
   assign mem_addr_o = r_maddr;
   assign mem_data_o = r_mdata;
   assign done_o     = r_done;
   assign err_o      = r_err_o;
   assign ovf_o      = r_ovf_o;

endmodule
`default_nettype wire

// File: doc/store_narrow_unit.md
# store_narrow_unit

Multi-cycle store path that narrows a 32-bit register value to byte, halfword or word width and writes it to an 8-bit-wide data memory, one byte per cycle, little-endian. It is the write-side counterpart of the load path's 16→32 sign extension. It sits between the datapath's store request and the byte-wide data memory port. A single req/ready handshake accepts one store at a time, and a one-cycle completion pulse reports done, alignment error and, optionally, a narrowing-overflow flag.

## Interface
- ADDR_W, 32, address width in bits.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  store request; accepted only when ready_o=1.
- addr_i  input  ADDR_W  byte address of the store.
- data_i  input  32  register value to store.
- size_i  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
- ready_o  output  1  unit idle and able to accept; reset 1.
- mem_we_o  output  1  byte write strobe; reset 0.
- mem_addr_o  output  ADDR_W  byte address for the current write; reset 0.
- mem_data_o  output  8  byte to write; reset 0.
- done_o  output  1  one-cycle completion pulse; reset 0.
- err_o  output  1  misaligned or illegal size, valid with done_o; reset 0.
- ovf_o  output  1  narrowing overflow, valid with done_o; reset 0.

## Operation
- States: IDLE, WRITE, DONE. Reset state is IDLE.
- IDLE: ready_o=1. If req_i=1, capture addr_i, data_i and size_i, then clear the byte counter.
  - Illegal request goes to DONE with err=1. A request is illegal if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
  - Legal request goes to WRITE.
- Byte count N: 1 for byte, 2 for halfword, 4 for word.
- WRITE: each cycle drives:
  - mem_we_o=1
  - mem_addr_o = base + cnt, modulo 2^ADDR_W
  - mem_data_o = data[8·cnt+7 : 8·cnt]
  - The counter increments each cycle. After the cycle with cnt=N−1, go to DONE.
- DONE: done_o=1 for exactly one cycle and mem_we_o=0. err_o and ovf_o hold the captured result for this cycle only and are 0 otherwise. Next state is IDLE.
- Error requests produce no memory write: mem_we_o stays 0 for the whole transaction.
- req_i is ignored outside IDLE. No queuing; the requester must hold req_i until it sees ready_o.
- mem_addr_o and mem_data_o are 0 whenever mem_we_o=0.
- Reset mid-operation: at the reset edge the FSM returns to IDLE and all outputs take their reset values. Remaining bytes are abandoned and no done_o is issued. A req_i sampled in the same cycle as rst_i=1 is dropped.

## Timing
- Accept edge is T0; outputs are registered.
- Legal store: mem_we_o is high for cycles T0+1 … T0+N. done_o is high in cycle T0+N+1. ready_o returns high in cycle T0+N+2.
- Error store: done_o/err_o are high in cycle T0+1. ready_o returns high in cycle T0+2.
- Back-to-back: the earliest next accept is the edge at the end of the first cycle in which ready_o=1 again. Throughput is one store per N+2 cycles.
- Address wrap: base 0xFFFF_FFFE with halfword writes 0xFFFF_FFFE then 0xFFFF_FFFF, with no error. Any access crossing 2^ADDR_W is already misaligned and is rejected.

## Configuration
- Macro: STORE_NARROW_OVF_CHECK_EN.
- Defined: ovf_o=1 with done_o when the captured value is not the sign extension of the stored width, while the store still completes truncated.
  - Byte: data[31:7] not all equal.
  - Halfword: data[31:15] not all equal.
  - Word: never.
  - Error requests: ovf_o=0.
- Not defined: the check logic is absent and ovf_o is tied to 0. The port remains.

## Test plan
- Word store: addr 0x100, data 0x11223344, size 10 → writes (0x100,0x44), (0x101,0x33), (0x102,0x22), (0x103,0x11) in T0+1..T0+4; done_o at T0+5 with err_o=0.
- Halfword and byte: addr 0x202, data 0xFFFF8001, size 01 → (0x202,0x01), (0x203,0x80), done, ovf_o=0. Byte store at 0x7, data 0x00000180 → single write (0x7,0x80); ovf_o=1 with the macro, 0 without.
- Misaligned: addr 0x101, size 10 → no mem_we_o; done_o=err_o=1 at T0+1. Size 11 at 0x0 → same response.
- Handshake: hold req_i=1 continuously with two queued stores → second accept only when ready_o=1, exactly N+2 cycles after the first. req_i pulses during WRITE are ignored.
- Reset mid-word-store: assert rst_i during the second write cycle → next cycle mem_we_o=0, ready_o=1, no done_o pulse. A fresh byte store then completes normally.
- Wrap: addr 0xFFFFFFFE, data 0x0000BEEF, size 01 → (0xFFFFFFFE,0xEF), (0xFFFFFFFF,0xBE), err_o=0.
